// File: rtl/scrambler_pkg.sv
// Shared constants, state type and single-step helper for the PCIe Gen1/2 scrambler LFSR.
// Optional build macro used by scrambler_lfsr_gen: SCRAMBLE_DISABLE_EN.
package scrambler_pkg;

    localparam int          LFSR_WIDTH        = 16;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hFFFF;
    localparam logic [7:0]  COM_SYMBOL        = 8'hBC;
    localparam logic [7:0]  SKP_SYMBOL        = 8'h1C;

    // x^16 + x^5 + x^4 + x^3 + 1: feedback lands on bits 5, 4, 3 and 0.
    localparam logic [15:0] LFSR_TAPS = 16'h0039;

    typedef logic [LFSR_WIDTH-1:0] lfsr_t;

    function automatic lfsr_t lfsr_step(input lfsr_t s);
        return {s[LFSR_WIDTH-2:0], 1'b0} ^ (s[LFSR_WIDTH-1] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/scrambler_lfsr_byte_step.sv
// One lane of the scrambler chain: applies COM/SKP/K/D rules to one symbol
// and produces the next LFSR state plus the lane's 8-bit scramble value.
module scrambler_lfsr_byte_step
    import scrambler_pkg::*;
#(
    parameter lfsr_t      SEED_VALUE = LFSR_SEED_DEFAULT,
    parameter logic [7:0] COM_VALUE  = 8'hBC,
    parameter logic [7:0] SKP_VALUE  = 8'h1C
) (
    input  lfsr_t      state_in,
    input  logic [7:0] symbol,
    input  logic       k,
    output lfsr_t      state_out,
    output logic [7:0] value
);

    lfsr_t      walk;
    logic [7:0] raw;

    // First serial bit out of the register becomes value[7].
    always_comb begin
        walk = state_in;
        raw  = '0;
        for (int i = 0; i < 8; i++) begin
            raw[7-i] = walk[LFSR_WIDTH-1];
            walk     = lfsr_step(walk);
        end
    end

    always_comb begin
        state_out = walk;
        value     = raw;
        if (k) begin
            value = 8'h00;
            if (symbol == COM_VALUE) begin
                state_out = SEED_VALUE;
            end else if (symbol == SKP_VALUE) begin
                state_out = state_in;
            end
        end
    end

endmodule

// File: rtl/scrambler_lfsr_gen.sv
// Four-lane scramble value generator: chains four byte steps per cycle and registers
// values alongside data/datak. Build macro SCRAMBLE_DISABLE_EN adds scramble_disable_i.
module scrambler_lfsr_gen
    import scrambler_pkg::*;
#(
    parameter lfsr_t      SEED       = LFSR_SEED_DEFAULT,
    parameter logic [7:0] COM_SYMBOL = scrambler_pkg::COM_SYMBOL,
    parameter logic [7:0] SKP_SYMBOL = scrambler_pkg::SKP_SYMBOL
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  datak_i,
`ifdef SCRAMBLE_DISABLE_EN
    input  logic        scramble_disable_i,
`endif
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic [3:0]  datak_o,
    output logic [7:0]  lfsr1_scramble_value_o,
    output logic [7:0]  lfsr2_scramble_value_o,
    output logic [7:0]  lfsr3_scramble_value_o,
    output logic [7:0]  lfsr4_scramble_value_o,
    output logic [15:0] lfsr_state_o
);

    lfsr_t            lfsr_q;
    logic [4:0][15:0] lane_state;
    logic [3:0][7:0]  lane_value;
    logic [3:0][7:0]  value_sel;
    logic [3:0][7:0]  value_q;
    logic             valid_q;
    logic [31:0]      data_q;
    logic [3:0]       datak_q;

    assign lane_state[0] = lfsr_q;

    // Lane n sees the state left by lane n-1 within the same cycle.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        scrambler_lfsr_byte_step #(
            .SEED_VALUE (SEED),
            .COM_VALUE  (COM_SYMBOL),
            .SKP_VALUE  (SKP_SYMBOL)
        ) u_step (
            .state_in  (lane_state[g]),
            .symbol    (data_i[8*g +: 8]),
            .k         (datak_i[g]),
            .state_out (lane_state[g+1]),
            .value     (lane_value[g])
        );
    end

`ifdef SCRAMBLE_DISABLE_EN
    // The LFSR still runs while disabled so the link stays in sync.
    assign value_sel = scramble_disable_i ? '0 : lane_value;
`else
    assign value_sel = lane_value;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q  <= SEED;
            valid_q <= 1'b0;
            data_q  <= '0;
            datak_q <= '0;
            value_q <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                lfsr_q  <= lane_state[4];
                data_q  <= data_i;
                datak_q <= datak_i;
                value_q <= value_sel;
            end
        end
    end

    assign valid_o                = valid_q;
    assign data_o                 = data_q;
    assign datak_o                = datak_q;
    assign lfsr1_scramble_value_o = value_q[0];
    assign lfsr2_scramble_value_o = value_q[1];
    assign lfsr3_scramble_value_o = value_q[2];
    assign lfsr4_scramble_value_o = value_q[3];
    assign lfsr_state_o           = lfsr_q;

endmodule
